// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of a 5-stage RV32I pipeline.
// Issues load/store requests to the data cache with byte-lane masks and
// lane-replicated store data, stalls until the cache responds (or the optional
// watchdog expires), then presents a registered MEM/WB result.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_*                     EX/MEM register contents (valid, op, funct3, address/ALU, rs2, PC)
//   data_mem_*               data cache request/response channel
//   mem_stall                holds IF..EX/MEM for this cycle
//   wb_*                     registered MEM/WB result, misaligned and timeout flags
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_pc,
  output logic [31:0] data_mem_address,
  output logic        data_mem_read,
  output logic        data_mem_write,
  output logic [31:0] data_mem_wdata,
  output logic [3:0]  data_mem_wmask,
  input  logic [31:0] data_mem_rdata,
  input  logic        data_mem_resp,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_mdr,
  output logic [3:0]  wb_rmask,
  output logic [31:0] wb_pc,
  output logic        wb_misaligned,
  output logic        wb_timeout
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q;
  logic [31:0]       addr_q, wdata_q, alu_q, pc_q;
  logic [3:0]        mask_q;
  logic              load_q;
  logic [CntW-1:0]   cnt_q;

  logic [1:0]  a;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        misaligned;
  logic        is_mem;
  logic        accept;
  logic        to_hit;
  logic        busy;

  // funct3[2] (unsigned) only matters to WB's extension.
  logic unused_funct3;
  assign unused_funct3 = in_funct3[2];

  assign a = in_alu_out[1:0];

  always_comb begin
    mask       = 4'b1111;
    wdata      = in_rs2;
    misaligned = 1'b0;
    unique case (in_funct3[1:0])
      2'b00: begin
        mask  = 4'b0001 << a;
        wdata = {4{in_rs2[7:0]}};
      end
      2'b01: begin
        mask       = 4'b0011 << a;
        wdata      = {2{in_rs2[15:0]}};
        misaligned = a[0];
      end
      default: begin
        mask       = 4'b1111;
        wdata      = in_rs2;
        misaligned = (a != 2'b00);
      end
    endcase
  end

  assign is_mem = in_mem_read | in_mem_write;
  assign busy   = (state_q == StBusy);
  assign accept = (state_q == StIdle) & in_valid & is_mem & ~misaligned;
  // Last permitted BUSY cycle; a resp in the same cycle takes priority.
  assign to_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 32'd1);

  // The instruction retires on resp or timeout, so the pipeline may advance then.
  assign mem_stall = rst & (busy ? ~(data_mem_resp | to_hit) : accept);

  assign data_mem_address = busy ? addr_q : 32'h0;
  assign data_mem_read    = busy & load_q;
  assign data_mem_write   = busy & ~load_q;
  assign data_mem_wdata   = data_mem_write ? wdata_q : 32'h0;
  assign data_mem_wmask   = data_mem_write ? mask_q : 4'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      alu_q         <= 32'h0;
      pc_q          <= 32'h0;
      mask_q        <= 4'h0;
      load_q        <= 1'b0;
      cnt_q         <= '0;
      wb_valid      <= 1'b0;
      wb_alu_out    <= 32'h0;
      wb_mdr        <= 32'h0;
      wb_rmask      <= 4'h0;
      wb_pc         <= 32'h0;
      wb_misaligned <= 1'b0;
      wb_timeout    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q  <= {in_alu_out[31:2], 2'b00};
            wdata_q <= wdata;
            mask_q  <= mask;
            load_q  <= in_mem_read;  // read+write together behaves as a load
            alu_q   <= in_alu_out;
            pc_q    <= in_pc;
            cnt_q   <= '0;
            state_q <= StBusy;
          end else if (in_valid) begin
            wb_valid      <= 1'b1;
            wb_alu_out    <= in_alu_out;
            wb_pc         <= in_pc;
            wb_mdr        <= 32'h0;
            wb_rmask      <= 4'h0;
            wb_misaligned <= is_mem;  // only reached by a mem op when misaligned
            wb_timeout    <= 1'b0;
          end
        end
        StBusy: begin
          if (data_mem_resp || to_hit) begin
            wb_valid      <= 1'b1;
            wb_alu_out    <= alu_q;
            wb_pc         <= pc_q;
            wb_mdr        <= (data_mem_resp && load_q) ? data_mem_rdata : 32'h0;
            wb_rmask      <= (data_mem_resp && load_q) ? mask_q : 4'h0;
            wb_misaligned <= 1'b0;
            wb_timeout    <= ~data_mem_resp;
            state_q       <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  a_no_rw_both: assert property (@(posedge clk) disable iff (!rst)
                                 !(in_valid && in_mem_read && in_mem_write))
    else $fatal(1, "mem_access_stage: load and store asserted together");

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, between the EX/MEM register and the WB stage.
- Issues load/store requests to the data cache and generates byte-lane read/write masks and lane-replicated store data.
- Stalls the pipeline until the cache responds, then presents a registered MEM/WB result (ALU result, raw loaded word, rmask, PC).
- WB selects, sign-extends or zero-extends the load lane from rmask.

Parameters:
TIMEOUT, 0, watchdog limit in cycles waiting for data_mem_resp; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  EX/MEM holds a valid instruction
in_mem_read  in  1  instruction is a load
in_mem_write  in  1  instruction is a store
in_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
in_alu_out  in  32  effective address, or ALU result
in_rs2  in  32  store source data
in_pc  in  32  instruction PC
data_mem_address  out  32  word-aligned address {addr[31:2],2'b00}
data_mem_read  out  1  read request
data_mem_write  out  1  write request
data_mem_wdata  out  32  lane-replicated store data
data_mem_wmask  out  4  byte write enables
data_mem_rdata  in  32  read data, valid with resp
data_mem_resp  in  1  one-cycle completion pulse
mem_stall  out  1  hold IF..EX/MEM this cycle
wb_valid  out  1  registered; MEM/WB holds a result
wb_alu_out  out  32  registered ALU result or address
wb_mdr  out  32  registered raw loaded word
wb_rmask  out  4  registered read lane mask
wb_pc  out  32  registered PC
wb_misaligned  out  1  registered; access dropped as misaligned
wb_timeout  out  1  registered; access abandoned by the watchdog

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; watchdog counter 0. Reset mid-access drops the request the same instant. A later resp is ignored.
- Masks, using a = in_alu_out[1:0]:
  - byte: mask 0001<<a.
  - half: mask 0011<<a.
  - word: mask 1111.
  - Store data: sb {4{rs2[7:0]}}, sh {2{rs2[15:0]}}, sw rs2.
- Misaligned accesses: half with a[0]=1; word with a!=0.
- States: IDLE, BUSY.
- IDLE, in_valid with no memory op, or a misaligned access:
  - No request is issued; mem_stall=0.
  - Next edge: wb_valid=1 and the wb_* fields are captured; wb_rmask=0.
  - wb_misaligned=1 only for the misaligned case.
- IDLE, in_valid with an aligned memory op:
  - mem_stall=1 combinationally.
  - Latch address, wdata, mask, op, pc, alu_out; go to BUSY.
  - wb_valid=0 on that edge.
- BUSY:
  - Drive data_mem_address, data_mem_read/write and wdata/wmask from the latches, stable until resp.
  - mem_stall = !data_mem_resp.
  - On resp: wb_mdr<=rdata (loads; 0 for stores); wb_rmask<=mask (loads; 0 for stores); wb_valid<=1; return to IDLE.
  - data_mem_read/write deassert in the cycle after resp.
- Minimum latency: a load whose resp arrives in the first BUSY cycle issues, then is in MEM/WB 2 edges after acceptance.
- Back-to-back: after BUSY->IDLE, IDLE accepts the next in_valid in the same cycle, so there is no bubble beyond the handshake.
- in_mem_read and in_mem_write both 1: illegal, $fatal in simulation. Synthesis treats it as a load.
- Watchdog (TIMEOUT>0):
  - Count cycles in BUSY.
  - When the count reaches TIMEOUT with no resp: deassert the request; wb_valid=1; wb_timeout=1; wb_mdr=0; return to IDLE.
  - A resp arriving on the same cycle as the timeout wins.
- data_mem_resp while IDLE is ignored.
- in_valid=0 in IDLE: wb_valid<=0; other wb_* fields hold.

Test Plan:
1. lb at 0x1003, resp after 3 BUSY cycles with rdata 0x80FF_0000 → data_mem_address=0x1000, mem_stall high for 4 cycles, wb_rmask=1000, wb_mdr=0x80FF_0000, wb_valid pulses once.
2. sh rs2=0x1234_ABCD at 0x2002 → data_mem_wmask=1100, data_mem_wdata=0xABCD_ABCD, address 0x2000, wb_rmask=0 after resp.
3. lw at 0x3001 → no data_mem_read, no stall, next-cycle wb_valid=1, wb_misaligned=1.
4. Back-to-back lw 0x10 then sw 0x14, resp immediate each time → two requests on consecutive BUSY windows, two wb_valid pulses, correct order.
5. TIMEOUT=8, resp never asserted → request drops after 8 BUSY cycles, wb_timeout=1; with resp on cycle 8 → normal completion, wb_timeout=0.
6. rst low during BUSY of an lw → all outputs 0 immediately; a resp after release is ignored; the next ADD passes through with wb_alu_out equal to its in_alu_out.
